// File: rtl/mux2_stream_arbiter_if.sv
// Stream bundle for the 2:1 arbiter: two valid/ready inputs plus the registered output beat.
// The master modport drives the inputs; the slave modport is the arbiter side.
interface mux2_stream_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              in0_valid;
   logic [DATA_W-1:0] in0_data;
   logic              in0_last;
   logic              in0_ready;
   logic              in1_valid;
   logic [DATA_W-1:0] in1_data;
   logic              in1_last;
   logic              in1_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_sel;
   logic              out_ready;

   modport master (
      output in0_valid, in0_data, in0_last,
      output in1_valid, in1_data, in1_last,
      output out_ready,
      input  in0_ready, in1_ready,
      input  out_valid, out_data, out_last, out_sel
   );

   modport slave (
      input  in0_valid, in0_data, in0_last,
      input  in1_valid, in1_data, in1_last,
      input  out_ready,
      output in0_ready, in1_ready,
      output out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// Round-robin 2:1 stream arbiter with packet locking and one registered output stage.
// Optional saturating per-input grant counters are enabled by MUX2_ARB_GRANT_CNT_EN.
module mux2_stream_arbiter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   mux2_stream_arbiter_if.slave bus,
   output logic [CNT_W-1:0] grant0_cnt,
   output logic [CNT_W-1:0] grant1_cnt
);

   typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} state_t;

   state_t            state_q, state_d;
   logic              rr_last;
   logic              load_en;
   logic              grant_vld;
   logic              grant_sel;
   logic [DATA_W-1:0] win_data;
   logic              win_last;

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              last_p1;
   logic              sel_p1;

   assign load_en = !vld_p1 || bus.out_ready;

   // Grant decision; a grant always implies the granted input is valid, so grant == accept.
   always_comb begin
      grant_vld = 1'b0;
      grant_sel = 1'b0;
      if (load_en) begin
         case (state_q)
            UNLOCKED: begin
               if (bus.in0_valid && bus.in1_valid) begin
                  grant_vld = 1'b1;
                  grant_sel = ~rr_last;
               end else if (bus.in0_valid) begin
                  grant_vld = 1'b1;
               end else if (bus.in1_valid) begin
                  grant_vld = 1'b1;
                  grant_sel = 1'b1;
               end
            end
            LOCK0: grant_vld = bus.in0_valid;
            LOCK1: begin
               grant_vld = bus.in1_valid;
               grant_sel = 1'b1;
            end
            default: grant_vld = 1'b0;
         endcase
      end
   end

   assign bus.in0_ready = grant_vld && !grant_sel;
   assign bus.in1_ready = grant_vld && grant_sel;
   assign win_data      = grant_sel ? bus.in1_data : bus.in0_data;
   assign win_last      = grant_sel ? bus.in1_last : bus.in0_last;

   always_comb begin
      state_d = state_q;
      if (grant_vld) begin
         case (state_q)
            UNLOCKED: if (!win_last) state_d = grant_sel ? LOCK1 : LOCK0;
            LOCK0,
            LOCK1:    if (win_last) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNLOCKED;
         rr_last <= 1'b1;
      end else begin
         state_q <= state_d;
         if (grant_vld) rr_last <= grant_sel;
      end
   end

   // Output stage p1: payload holds whenever no beat is loaded, so a dropped valid keeps old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
         sel_p1  <= 1'b0;
      end else if (load_en) begin
         vld_p1 <= grant_vld;
         if (grant_vld) begin
            data_p1 <= win_data;
            last_p1 <= win_last;
            sel_p1  <= grant_sel;
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_last  = last_p1;
   assign bus.out_sel   = sel_p1;

`ifdef MUX2_ARB_GRANT_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (grant_vld) begin
         if (grant_sel) cnt1_q <= sat_inc(cnt1_q);
         else           cnt0_q <= sat_inc(cnt0_q);
      end
   end

   assign grant0_cnt = cnt0_q;
   assign grant1_cnt = cnt1_q;
`else
   assign grant0_cnt = '0;
   assign grant1_cnt = '0;
`endif

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Upstream control stage for the 2:1 data mux. It arbitrates two valid/ready input streams and produces the registered select together with the winning data.
- It applies round-robin fairness with packet locking, so a multi-beat packet is never interleaved with the other input.
- One output register stage feeds the downstream consumer.

Parameters:
- DATA_W, 8, width of each data path.
- CNT_W, 16, width of the per-input grant counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  input 0 beat available.
- in0_data  input  DATA_W  input 0 payload.
- in0_last  input  1  input 0 final beat of packet.
- in0_ready  output  1  input 0 beat accepted this cycle.
- in1_valid  input  1  input 1 beat available.
- in1_data  input  DATA_W  input 1 payload.
- in1_last  input  1  input 1 final beat of packet.
- in1_ready  output  1  input 1 beat accepted this cycle.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered winning payload.
- out_last  output  1  registered last flag.
- out_sel  output  1  registered select: 0 means in0 won, 1 means in1 won.
- out_ready  input  1  downstream accepts the out beat.
- grant0_cnt  output  CNT_W  beats accepted from in0.
- grant1_cnt  output  CNT_W  beats accepted from in1.

Behaviour:
- Interface is fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Lock state is UNLOCKED; round-robin pointer rr_last=1, so in0 wins the first contention.
  - Counters are 0.
- Load rule: load_en = !out_valid || out_ready. The output register loads only when load_en=1.
- Grant (combinational, evaluated only when load_en=1):
  - UNLOCKED, one input valid: grant that input.
  - UNLOCKED, both valid: grant the input != rr_last.
  - LOCK0: grant in0 only if in0_valid; in1 is never granted.
  - LOCK1: grant in1 only if in1_valid; in0 is never granted.
  - Otherwise: no grant.
- Handshakes:
  - inK_ready = load_en && grant==K. At most one ready is high per cycle.
  - A beat is accepted when inK_valid && inK_ready.
  - in*_ready depends combinationally on out_ready. There is no combinational path from in*_valid to out_valid.
- On acceptance from input K:
  - out_data, out_last and out_sel capture in K's data, K's last flag, and K. out_valid=1.
  - rr_last=K.
- If load_en=1 and there is no grant: out_valid goes to 0 and out_data/out_last/out_sel hold their values.
- If load_en=0: all output registers hold. Data must stay stable while out_valid && !out_ready.
- Latency: 1 cycle from acceptance to out_valid. Full throughput is 1 beat per cycle when out_ready is held high.
- Lock FSM (states UNLOCKED, LOCK0, LOCK1):
  - UNLOCKED -> LOCKK on accepting a beat from K with last=0.
  - LOCKK -> UNLOCKED on accepting a beat from K with last=1.
  - A single-beat packet (last=1) leaves the FSM in UNLOCKED.
  - While locked, if the locked input deasserts valid, the bubble propagates: no grant, and the other input waits even if valid.
- Reset mid-packet: lock is cleared, the pending out beat is dropped, rr_last=1.
- X on an invalid input's data or last must not reach the outputs.

Optional Feature:
- Macro: MUX2_ARB_GRANT_CNT_EN.
- Defined:
  - grant0_cnt/grant1_cnt each increment by 1 on every accepted beat from their input.
  - They saturate at 2^CNT_W-1 (no wrap) and reset to 0.
- Undefined:
  - The ports remain present, tied to 0.
  - No counter flops are inferred.

Test Plan:
- Reset, then in0 only, single beats 0x11, 0x22 (last=1) with out_ready=1 -> out_data 0x11 then 0x22 on consecutive cycles, out_sel=0, 1-cycle latency, in1_ready=0 throughout.
- Both valid continuously, all last=1, in0 data 0xA0.., in1 data 0xB0.. -> out_sel sequence 0,1,0,1. First out beat is 0xA0.
- in1 sends a 3-beat packet (last on beat 3) while in0 is valid throughout -> out_sel=1 for 3 consecutive beats. in0 is granted on the next cycle. Insert an in1_valid gap mid-packet -> out_valid drops for that cycle and in0_ready stays 0.
- out_ready held 0 for 4 cycles with out_valid=1 -> out_data/out_sel stable, both in*_ready=0. Raise out_ready -> next beat loads the same cycle and no beat is lost or duplicated.
- Assert rst_n=0 asynchronously mid-packet on in0 -> out_valid=0 immediately and lock cleared. After release with both valid, in0 wins first.
- With MUX2_ARB_GRANT_CNT_EN and CNT_W=2, accept 5 beats from in0 -> grant0_cnt=3 (saturated), grant1_cnt=0. Without the macro, both stay 0.
